// File: rtl/sequencer_pkg.sv
// Shared types for the sequencer: state bus encoding, halt causes and widths.
// Breakpoint support is built only when SEQ_BREAKPOINT_EN is defined.
package sequencer_pkg;

  localparam int unsigned OPCODE_WIDTH = 8;
  localparam int unsigned IP_WIDTH     = 8;
  localparam int unsigned STATE_WIDTH  = 4;
  localparam int unsigned CAUSE_WIDTH  = 2;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = '1;

  // Encoding seen by core; SIDLE/SHALT decode there as all enables off.
  typedef enum logic [STATE_WIDTH-1:0] {
    SRST   = 4'd0,
    SR1    = 4'd1,
    SR2    = 4'd2,
    SR3    = 4'd3,
    SR4    = 4'd4,
    SCALC  = 4'd5,
    SWRITE = 4'd6,
    SNXT   = 4'd7,
    SIDLE  = 4'd8,
    SHALT  = 4'd9
  } SequencerState;

  typedef enum logic [CAUSE_WIDTH-1:0] {
    HC_NONE    = 2'd0,
    HC_HALTOP  = 2'd1,
    HC_TIMEOUT = 2'd2,
    HC_BREAK   = 2'd3
  } HaltCause;

  // States that count toward the cycles counter.
  function automatic logic is_active(SequencerState s);
    return !(s inside {SRST, SIDLE, SHALT});
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module seq_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sequencer.sv
// Control FSM driving core through fetch/read/calc/write, with RAM stall timeout,
// HALT opcode, single-step and counters. SEQ_BREAKPOINT_EN adds an ip breakpoint.
module sequencer
  import sequencer_pkg::*;
#(
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int unsigned             STALL_MAX   = 16,
  parameter int unsigned             CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    run,
  input  logic                    step_mode,
  input  logic                    step,
  input  logic                    resume,
  input  logic                    ram_busy,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [IP_WIDTH-1:0]     ip,
`ifdef SEQ_BREAKPOINT_EN
  input  logic                    bp_valid,
  input  logic [IP_WIDTH-1:0]     bp_addr,
`endif
  output logic [STATE_WIDTH-1:0]  q,
  output logic                    halted,
  output logic [CAUSE_WIDTH-1:0]  halt_cause,
  output logic [CNT_WIDTH-1:0]    retired,
  output logic [CNT_WIDTH-1:0]    cycles
);

  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  SequencerState        state_q, state_d;
  HaltCause             cause_q, cause_d;
  logic [STALL_W-1:0]   stall_q, stall_d, stall_inc;
  logic                 retire;

`ifdef SEQ_BREAKPOINT_EN
  logic                 bp_block_q, bp_block_d;
  logic [IP_WIDTH-1:0]  bp_ip_q, bp_ip_d;
  logic                 bp_hit;

  // A breakpoint just taken stays masked until ip moves away from it.
  assign bp_hit = bp_valid && (ip == bp_addr) && !(bp_block_q && (ip == bp_ip_q));
`else
  logic unused_inputs;
  assign unused_inputs = ^{resume, ip};
`endif

  assign stall_inc = stall_q + STALL_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= SRST;
      cause_q    <= HC_NONE;
      halted     <= 1'b0;
      stall_q    <= '0;
`ifdef SEQ_BREAKPOINT_EN
      bp_block_q <= 1'b0;
      bp_ip_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      halted     <= (state_d == SHALT);
      stall_q    <= stall_d;
`ifdef SEQ_BREAKPOINT_EN
      bp_block_q <= bp_block_d;
      bp_ip_q    <= bp_ip_d;
`endif
    end
  end

  // Next-state: RAM stages hold on ram_busy and a timeout overrides the hold.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    stall_d    = '0;
    retire     = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    bp_block_d = bp_block_q && (ip == bp_ip_q);
    bp_ip_d    = bp_ip_q;
`endif

    case (state_q)
      SRST: begin
        if (run) state_d = SR1;
      end
      SR1: state_d = SR2;
      SR2, SR3, SWRITE: begin
        if (ram_busy) begin
          stall_d = stall_inc;
          if (stall_inc == STALL_W'(STALL_MAX)) begin
            state_d = SHALT;
            cause_d = HC_TIMEOUT;
            stall_d = '0;
          end
        end else if (state_q == SR2) begin
          state_d = SR3;
        end else if (state_q == SR3) begin
          state_d = SR4;
        end else begin
          state_d = SNXT;
          retire  = 1'b1;
        end
      end
      SR4: state_d = SCALC;
      SCALC: begin
        if (opcode == HALT_OPCODE) begin
          state_d = SHALT;
          cause_d = HC_HALTOP;
        end else begin
          state_d = SWRITE;
        end
      end
      SNXT: begin
`ifdef SEQ_BREAKPOINT_EN
        if (bp_hit) begin
          state_d    = SHALT;
          cause_d    = HC_BREAK;
          bp_block_d = 1'b1;
          bp_ip_d    = ip;
        end else
`endif
        if (step_mode) begin
          state_d = SIDLE;
        end else begin
          state_d = SR1;
        end
      end
      SIDLE: begin
        if (step || !step_mode) state_d = SR1;
      end
      SHALT: begin
`ifdef SEQ_BREAKPOINT_EN
        if (resume && (cause_q == HC_BREAK)) begin
          state_d = SR1;
          cause_d = HC_NONE;
        end
`endif
      end
      default: state_d = SRST;
    endcase
  end

  assign q          = state_q;
  assign halt_cause = cause_q;

  seq_sat_counter #(.WIDTH(CNT_WIDTH)) u_retired (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (retire),
    .clr   (1'b0),
    .count (retired)
  );

  seq_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycles (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (is_active(state_q)),
    .clr   (1'b0),
    .count (cycles)
  );

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: instruction-level reference model checked every cycle,
// plus literal checkpoints. Breakpoint scenario runs when SEQ_BREAKPOINT_EN is defined.
module tb_sequencer;
  import sequencer_pkg::*;

  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int          SMAX = 16;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OP = '1;

  logic                    clk;
  logic                    rstn;
  logic                    run, step_mode, step, resume, ram_busy;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [IP_WIDTH-1:0]     ip;
  logic                    bp_valid;
  logic [IP_WIDTH-1:0]     bp_addr;
  logic [STATE_WIDTH-1:0]  q;
  logic                    halted;
  logic [CAUSE_WIDTH-1:0]  halt_cause;
  logic [CW-1:0]           retired, cycles;

  int total = 0;
  int bad   = 0;

  // reference model state
  SequencerState m_q;
  int  m_cause, m_retired, m_cycles, m_stall, m_ip;
  bit  m_halted;
  bit  m_bp_blk;
  int  m_bp_ip;

  sequencer #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .run        (run),
    .step_mode  (step_mode),
    .step       (step),
    .resume     (resume),
    .ram_busy   (ram_busy),
    .opcode     (opcode),
    .ip         (ip),
`ifdef SEQ_BREAKPOINT_EN
    .bp_valid   (bp_valid),
    .bp_addr    (bp_addr),
`endif
    .q          (q),
    .halted     (halted),
    .halt_cause (halt_cause),
    .retired    (retired),
    .cycles     (cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_q = SRST; m_cause = 0; m_retired = 0; m_cycles = 0;
    m_stall = 0; m_ip = 0; m_halted = 0; m_bp_blk = 0; m_bp_ip = 0;
  endtask

  // One clock of the instruction-level behaviour, from the current inputs.
  task automatic model_step();
    SequencerState nx;
    bit hit;
    nx = m_q;
    if (!(m_q inside {SRST, SIDLE, SHALT}) && m_cycles < CMAX) m_cycles++;
    if ((m_q inside {SR2, SR3, SWRITE}) && ram_busy) begin
      m_stall++;
      if (m_stall >= SMAX) begin
        nx = SHALT;
        m_cause = 2;
      end
    end else begin
      m_stall = 0;
      case (m_q)
        SRST:   if (run) nx = SR1;
        SR1:    nx = SR2;
        SR2:    nx = SR3;
        SR3:    nx = SR4;
        SR4:    nx = SCALC;
        SCALC:  begin
          if (opcode == HALT_OP) begin nx = SHALT; m_cause = 1; end
          else nx = SWRITE;
        end
        SWRITE: begin
          nx = SNXT;
          if (m_retired < CMAX) m_retired++;
        end
        SNXT: begin
          hit = 0;
`ifdef SEQ_BREAKPOINT_EN
          hit = bp_valid && (ip == bp_addr) && !(m_bp_blk && int'(ip) == m_bp_ip);
`endif
          if (hit) begin
            nx = SHALT; m_cause = 3; m_bp_blk = 1; m_bp_ip = int'(ip);
          end else begin
            nx = step_mode ? SIDLE : SR1;
          end
          m_ip++;
        end
        SIDLE:  if (step || !step_mode) nx = SR1;
        SHALT: begin
`ifdef SEQ_BREAKPOINT_EN
          if (resume && m_cause == 3) begin nx = SR1; m_cause = 0; end
`endif
        end
        default: nx = SRST;
      endcase
    end
    if (m_bp_blk && !(m_q == SNXT && nx == SHALT && m_cause == 3) && int'(ip) != m_bp_ip)
      m_bp_blk = 0;
    m_q = nx;
    m_halted = (nx == SHALT);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // core's ip: advances each time an instruction leaves SNXT
  initial begin
    ip = '0;
    forever begin
      @(negedge clk);
      ip = IP_WIDTH'(m_ip);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("q",          32'(q),          32'(m_q));
    check("halted",     32'(halted),     32'(m_halted));
    check("halt_cause", 32'(halt_cause), 32'(m_cause));
    check("retired",    32'(retired),    32'(m_retired));
    check("cycles",     32'(cycles),     32'(m_cycles));
  endtask

  task automatic tick();
    @(negedge clk);
    if (rstn) compare_all();
  endtask

  task automatic wait_q(input string name, input SequencerState target, input int budget);
    int n = 0;
    while (q !== target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(q), 32'(target));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    ram_busy = 1'b0; opcode = '0; bp_valid = 1'b0; bp_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_q",       32'(q),          32'(SRST));
    check("rst_halted",  32'(halted),     32'd0);
    check("rst_cause",   32'(halt_cause), 32'd0);
    check("rst_retired", 32'(retired),    32'd0);
    check("rst_cycles",  32'(cycles),     32'd0);
    rstn = 1'b1;
  endtask

  SequencerState seq [8];

  initial begin
    rstn = 1'b0;
    seq = '{SR1, SR2, SR3, SR4, SCALC, SWRITE, SNXT, SR1};

    // basic sequence, short stall, run drop, HALT opcode
    apply_reset();
    repeat (5) tick();
    check("idle_q", 32'(q), 32'(SRST));
    check("idle_cycles", 32'(cycles), 32'd0);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("seq", 32'(q), 32'(seq[i]));
    end
    check("first_retired", 32'(retired), 32'd1);
    check("first_cycles", 32'(cycles), 32'd7);
    tick();
    check("stall_enter", 32'(q), 32'(SR2));
    ram_busy = 1'b1;
    repeat (3) begin
      tick();
      check("stall_hold", 32'(q), 32'(SR2));
    end
    ram_busy = 1'b0;
    tick();
    check("stall_release", 32'(q), 32'(SR3));
    run = 1'b0;
    wait_q("wait_snxt2", SNXT, 20);
    check("second_retired", 32'(retired), 32'd2);
    check("second_cycles", 32'(cycles), 32'd16);
    wait_q("wait_sr4", SR4, 20);
    opcode = HALT_OP;
    tick();
    check("calc_q", 32'(q), 32'(SCALC));
    tick();
    opcode = '0;
    check("haltop_q", 32'(q), 32'(SHALT));
    check("haltop_cause", 32'(halt_cause), 32'd1);
    check("haltop_halted", 32'(halted), 32'd1);
    check("haltop_retired", 32'(retired), 32'd2);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    run = 1'b1;
    repeat (4) tick();
    check("haltop_sticky", 32'(q), 32'(SHALT));
    check("haltop_sticky_cause", 32'(halt_cause), 32'd1);

    // stall counter clears between stages, then times out
    apply_reset();
    run = 1'b1;
    wait_q("wait_sr2", SR2, 10);
    ram_busy = 1'b1;
    repeat (10) tick();
    ram_busy = 1'b0;
    tick();
    check("to_sr3", 32'(q), 32'(SR3));
    ram_busy = 1'b1;
    repeat (SMAX - 1) tick();
    check("to_last_stall", 32'(q), 32'(SR3));
    tick();
    check("to_q", 32'(q), 32'(SHALT));
    check("to_cause", 32'(halt_cause), 32'd2);
    check("to_halted", 32'(halted), 32'd1);
    check("to_retired", 32'(retired), 32'd0);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    ram_busy = 1'b0;
    repeat (3) tick();
    check("to_resume_ignored", 32'(q), 32'(SHALT));

    // single-step mode, then free run to saturation
    apply_reset();
    step_mode = 1'b1;
    run = 1'b1;
    wait_q("wait_sidle", SIDLE, 20);
    check("step0_retired", 32'(retired), 32'd1);
    repeat (3) tick();
    check("sidle_hold", 32'(q), 32'(SIDLE));
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      check("step_release", 32'(q), 32'(SR1));
      if (k == 1) begin
        wait_q("wait_sr3_step", SR3, 10);
        step = 1'b1;
        tick();
        step = 1'b0;
      end
      wait_q("wait_sidle_k", SIDLE, 20);
      check("step_retired", 32'(retired), 32'(2 + k));
    end
    step_mode = 1'b0;
    tick();
    check("leave_step_mode", 32'(q), 32'(SR1));
    repeat (460) tick();
    check("sat_retired", 32'(retired), 32'd63);
    check("sat_cycles", 32'(cycles), 32'd63);

`ifdef SEQ_BREAKPOINT_EN
    // breakpoint at ip 4, resume continues past it
    apply_reset();
    bp_valid = 1'b1;
    bp_addr  = 8'h04;
    run = 1'b1;
    wait_q("wait_bp", SHALT, 100);
    check("bp_cause", 32'(halt_cause), 32'd3);
    check("bp_retired", 32'(retired), 32'd5);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("bp_resume_q", 32'(q), 32'(SR1));
    check("bp_resume_cause", 32'(halt_cause), 32'd0);
    repeat (28) tick();
    check("bp_continue_retired", 32'(retired), 32'd9);
    check("bp_continue_halted", 32'(halted), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
